// File: rtl/dmem_pkg.sv
// Shared types for the sized big-endian data memory: size codes, error codes,
// FSM states and the registered response payload.
package dmem_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    err_e            err;
  } resp_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_extend.sv
// Picks the addressed big-endian lanes out of an aligned doubleword and
// sign- or zero-extends them to XLEN.
module dmem_extend
  import dmem_pkg::*;
(
  input  logic [XLEN-1:0] dword_i,
  input  logic [2:0]      offset_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_c
);

  logic [XLEN-1:0] msb_aligned;
  logic [6:0]      rsh;

  // Move the datum to the top, then shift back down with the chosen fill.
  always_comb begin
    msb_aligned = dword_i << {offset_i, 3'b000};
    rsh         = 7'(XLEN) - 7'({size_bytes(size_i), 3'b000});
    if (unsigned_i) begin
      data_c = msb_aligned >> rsh;
    end else begin
      data_c = XLEN'($signed(msb_aligned) >>> rsh);
    end
  end

endmodule

// File: rtl/sized_data_mem.sv
// Byte-addressed big-endian data memory with sized loads/stores, alignment
// and range checking, and a fixed-latency valid/ready response.
module sized_data_mem
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [1:0]      resp_err
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  // Contents are never reset; they start at zero only.
  logic [7:0] mem_q [DEPTH_BYTES] = '{default: 8'h00};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  resp_t            resp_q, resp_d;

  logic             accept_c;
  logic             we_c;
  logic [3:0]       nbytes_c;
  err_e             err_c;
  logic [AW-1:0]    idx_c;
  logic [XLEN-1:0]  dword_c;
  logic [XLEN-1:0]  ext_c;
  logic [XLEN-1:0]  wdata_msb_c;

  // Request decode: error classification with misalignment taking priority.
  always_comb begin
    nbytes_c = size_bytes(req_size);
    idx_c    = req_addr[AW-1:0];
    if ((req_addr[2:0] & 3'(nbytes_c - 4'd1)) != 3'b000) begin
      err_c = ERR_MISALIGN;
    end else if (({1'b0, req_addr} + 65'(nbytes_c)) > 65'(DEPTH_BYTES)) begin
      err_c = ERR_RANGE;
    end else begin
      err_c = ERR_OK;
    end
    accept_c    = req_valid && req_ready_q;
    we_c        = accept_c && req_write && (err_c == ERR_OK);
    wdata_msb_c = req_wdata << (7'(XLEN) - 7'({nbytes_c, 3'b000}));
  end

  // Aligned doubleword containing the address, lowest address in the MSBs.
  always_comb begin
    dword_c = '0;
    for (int k = 0; k < 8; k++) begin
      dword_c[XLEN-1-8*k -: 8] = mem_q[(idx_c & ~AW'(7)) | AW'(k)];
    end
  end

  dmem_extend u_extend (
    .dword_i    (dword_c),
    .offset_i   (req_addr[2:0]),
    .size_i     (req_size),
    .unsigned_i (req_unsigned),
    .data_c     (ext_c)
  );

  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < nbytes_c) begin
          mem_q[idx_c + AW'(k)] <= wdata_msb_c[XLEN-1-8*k -: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          resp_d.err   = err_c;
          resp_d.rdata = (req_write || (err_c != ERR_OK)) ? '0 : ext_c;
          cnt_d        = '0;
          state_d      = (RD_LATENCY <= 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(RD_LATENCY - 2)) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_q.rdata;
  assign resp_err   = resp_q.err;

endmodule

// File: tb/tb_sized_data_mem.sv
// Scoreboard bench for sized_data_mem at RD_LATENCY=3, DEPTH_BYTES=1024.
module tb_sized_data_mem;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_err;

  typedef struct packed {
    logic [63:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sized_data_mem #(
    .DEPTH_BYTES (1024),
    .RD_LATENCY  (LAT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(req_ready), 64'd1);
  endtask

  // Issue one request, check latency/hold behaviour, then compare against the scoreboard.
  task automatic run_op(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_d, input logic [1:0] exp_e, input int hold);
    exp_t e;
    exp_q.push_back({exp_d, exp_e});
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    wait_ready("accept");
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'b1; req_size = 2'd3;
    req_addr = 64'h10; req_wdata = {$urandom, $urandom};
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      check_eq("rvalid_lat", 64'(resp_valid), 64'(c == LAT));
      check_eq("rdy_busy", 64'(req_ready), 64'd0);
    end
    e = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check_eq("hold_rdata", resp_rdata, e.rdata);
      @(negedge clk);
      check_eq("hold_valid", 64'(resp_valid), 64'd1);
      check_eq("hold_rdy", 64'(req_ready), 64'd0);
    end
    check_eq("rdata", resp_rdata, e.rdata);
    check_eq("err", 64'(resp_err), 64'(e.err));
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check_eq("post_valid", 64'(resp_valid), 64'd0);
    check_eq("post_rdy", 64'(req_ready), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_rdy", 64'(req_ready), 64'd0);
    check_eq("rst_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_rdata", resp_rdata, 64'd0);
    check_eq("rst_err", 64'(resp_err), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rdy_after_rst", 64'(req_ready), 64'd1);

    run_op(1, 2'd3, 0, 64'h10, 64'h0123456789ABCDEF, 64'h0, 2'd0, 0);
    run_op(0, 2'd0, 1, 64'h10, 64'h0, 64'h01, 2'd0, 0);
    run_op(0, 2'd0, 0, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFFEF, 2'd0, 0);
    run_op(0, 2'd3, 0, 64'h10, 64'h0, 64'h0123456789ABCDEF, 2'd0, 0);
    run_op(0, 2'd2, 0, 64'h14, 64'h0, 64'hFFFFFFFF89ABCDEF, 2'd0, 5);
    run_op(0, 2'd1, 0, 64'h12, 64'h0, 64'h4567, 2'd0, 0);
    run_op(1, 2'd1, 0, 64'h20, 64'hFFFFFFFFFFFF8001, 64'h0, 2'd0, 0);
    run_op(0, 2'd1, 0, 64'h20, 64'h0, 64'hFFFFFFFFFFFF8001, 2'd0, 0);
    run_op(0, 2'd1, 1, 64'h20, 64'h0, 64'h8001, 2'd0, 0);
    run_op(0, 2'd0, 1, 64'h22, 64'h0, 64'h0, 2'd0, 0);
    run_op(0, 2'd2, 1, 64'h22, 64'h0, 64'h0, 2'd1, 0);
    run_op(1, 2'd2, 0, 64'h3FC, 64'hCAFEF00D, 64'h0, 2'd0, 0);
    run_op(1, 2'd3, 0, 64'h3FC, 64'hFFFFFFFFFFFFFFFF, 64'h0, 2'd1, 0);
    run_op(0, 2'd2, 1, 64'h3FC, 64'h0, 64'hCAFEF00D, 2'd0, 0);
    run_op(1, 2'd2, 0, 64'h400, 64'h12345678, 64'h0, 2'd2, 0);
    run_op(0, 2'd0, 1, 64'h3FF, 64'h0, 64'h0D, 2'd0, 0);
    run_op(0, 2'd0, 1, 64'h400, 64'h0, 64'h0, 2'd2, 0);
    run_op(0, 2'd1, 1, 64'h3FF, 64'h0, 64'h0, 2'd1, 0);
    run_op(1, 2'd3, 0, 64'hFFFFFFFFFFFFFFF8, 64'h1122334455667788, 64'h0, 2'd2, 2);
    run_op(0, 2'd3, 0, 64'h0, 64'h0, 64'h0, 2'd0, 0);
    run_op(1, 2'd0, 0, 64'h7, 64'h5A, 64'h0, 2'd0, 0);

    // Reset while the store of 0xAA to 0x5 is still waiting for its response.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'h5; req_wdata = 64'hAA;
    wait_ready("accept_rst");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(resp_valid), 64'd0);
    check_eq("midrst_rdy", 64'(req_ready), 64'd0);
    @(negedge clk);
    check_eq("midrst_valid2", 64'(resp_valid), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_rdy_back", 64'(req_ready), 64'd1);

    run_op(0, 2'd0, 1, 64'h5, 64'h0, 64'hAA, 2'd0, 0);
    run_op(0, 2'd3, 1, 64'h0, 64'h0, 64'h0000000000AA005A, 2'd0, 0);
    run_op(0, 2'd3, 1, 64'h10, 64'h0, 64'h0123456789ABCDEF, 2'd0, 0);

    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
